tcm_enc_4d_8psk: RTL and testbench

- Transmit-side 4D-8PSK TCM encoder and mapper. Decoder branch metrics in the decode path are computed against this block's output.
- Accepts one info word per 4D symbol at 8/9/10/11 bits (coderate 2/2.25/2.5/2.75 bits per 8PSK symbol).
- Runs a 64-state systematic feedback rate-2/3 convolutional encoder on the two LSBs.
- Maps the 12-bit coded vector to four 3-bit 8PSK phase indices.
- Frames the output stream with sop/eop and a valid/ready handshake toward the modulator.

---
 rtl/tcm_enc_4d_8psk_pkg.sv | 55 +++++
 rtl/tcm_enc_4d_8psk_conv.sv | 41 ++++
 rtl/tcm_enc_4d_8psk.sv | 154 +++++++++++++++
 tb/tb_tcm_enc_4d_8psk.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tcm_enc_4d_8psk_pkg.sv
// Shared types, default parity-check polynomials and the 4D-8PSK mapper for tcm_enc_4d_8psk.
package tcm_enc_types;

  typedef logic [2:0]       symb_idx_t;
  typedef logic [3:0][2:0]  symb4_t;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [6:0] cH0 = 7'o103;
  localparam logic [6:0] cH1 = 7'o030;
  localparam logic [6:0] cH2 = 7'o066;

  // Row j is coded bit j = {p, w0..w10}; column k is the contribution to z_k.
  localparam symb_idx_t cGEN [12][4] = '{
    '{3'd1, 3'd1, 3'd1, 3'd1},
    '{3'd0, 3'd2, 3'd0, 3'd2},
    '{3'd0, 3'd0, 3'd2, 3'd2},
    '{3'd0, 3'd0, 3'd0, 3'd2},
    '{3'd2, 3'd2, 3'd2, 3'd2},
    '{3'd0, 3'd0, 3'd0, 3'd4},
    '{3'd0, 3'd0, 3'd4, 3'd0},
    '{3'd0, 3'd4, 3'd0, 3'd0},
    '{3'd4, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd1, 3'd0, 3'd1},
    '{3'd0, 3'd0, 3'd1, 3'd1},
    '{3'd0, 3'd0, 3'd0, 3'd1}
  };

  function automatic logic [3:0] code_width(input logic [1:0] code);
    return 4'd8 + {2'b00, code};
  endfunction

  function automatic logic [10:0] info_mask(input logic [1:0] code);
    logic [10:0] m;
    case (code)
      2'd0:    m = 11'h0FF;
      2'd1:    m = 11'h1FF;
      2'd2:    m = 11'h3FF;
      default: m = 11'h7FF;
    endcase
    return m;
  endfunction

  function automatic symb4_t map4d(input logic [11:0] c);
    symb4_t z;
    z = '0;
    for (int unsigned j = 0; j < 12; j++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (c[j]) z[k] = z[k] + cGEN[j][k];
      end
    end
    return z;
  endfunction

endpackage

// File: rtl/tcm_enc_4d_8psk_conv.sv
// 64-state systematic feedback rate-2/3 convolutional encoder: state register, parity and next state.
module tcm_enc_conv
  import tcm_enc_types::*;
#(
  parameter logic [6:0] pH0 = cH0,
  parameter logic [6:0] pH1 = cH1,
  parameter logic [6:0] pH2 = cH2
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iclr,
  input  logic iupd,
  input  logic ix1,
  input  logic ix2,
  output logic op
);

  logic [5:0] s_q;
  logic [5:0] s_d;
  logic [5:0] s_cur;

  // A clear applies to the word being encoded, not just the next one.
  assign s_cur = iclr ? '0 : s_q;
  assign op    = s_cur[5];

  always_comb begin
    s_d = s_q;
    if (iupd) begin
      s_d = {s_cur[4:0], 1'b0}
          ^ ({6{ix1}} & pH1[5:0])
          ^ ({6{ix2}} & pH2[5:0])
          ^ ({6{op}}  & pH0[5:0]);
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) s_q <= '0;
    else        s_q <= s_d;
  end

endmodule

// File: rtl/tcm_enc_4d_8psk.sv
// 4D-8PSK TCM encoder/mapper with sop/eop framing and valid/ready output register.
// Optional 180-degree differential rotation of the top uncoded bit: define TCM_ENC_DIFF_EN.
module tcm_enc_4d_8psk
  import tcm_enc_types::*;
#(
  parameter logic [6:0]  pH0    = cH0,
  parameter logic [6:0]  pH1    = cH1,
  parameter logic [6:0]  pH2    = cH2,
  parameter int unsigned pLEN_W = 16
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [1:0]        icode,
  input  logic [pLEN_W-1:0] ilen,
  input  logic              ival,
  input  logic              isop,
  input  logic [10:0]       idat,
  output logic              ordy,
  input  logic              iordy,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [3:0][2:0]   osymb,
  output logic              oerr
);

  state_t            state_q, state_d;
  logic [pLEN_W-1:0] len_q, len_d;
  logic [pLEN_W-1:0] cnt_q, cnt_d;
  logic              oval_q, oval_d;
  logic              osop_q, osop_d;
  logic              oeop_q, oeop_d;
  logic              oerr_q, oerr_d;
  symb4_t            osymb_q, osymb_d;

  logic              accept;
  logic [10:0]       w;
  logic              p;
  symb4_t            mapped;
  symb4_t            symb_w;
  logic [pLEN_W-1:0] len_eff;
  logic [pLEN_W-1:0] cnt_inc;

  assign ordy    = ~oval_q | iordy;
  assign accept  = iclkena & ival & ordy;
  assign w       = idat & info_mask(icode);
  assign len_eff = (ilen == '0) ? pLEN_W'(1) : ilen;
  assign cnt_inc = cnt_q + pLEN_W'(1);

  tcm_enc_conv #(
    .pH0 (pH0),
    .pH1 (pH1),
    .pH2 (pH2)
  ) u_conv (
    .iclk   (iclk),
    .ireset (ireset),
    .iclr   (isop),
    .iupd   (accept),
    .ix1    (w[0]),
    .ix2    (w[1]),
    .op     (p)
  );

  assign mapped = map4d({w, p});

`ifdef TCM_ENC_DIFF_EN
  symb_idx_t phi_q, phi_d;
  symb_idx_t phi_cur;
  logic      u;

  assign phi_cur = isop ? '0 : phi_q;
  assign u       = w[code_width(icode) - 4'd1];

  always_comb begin
    phi_d = phi_q;
    if (accept) phi_d = phi_cur + {u, 2'b00};
    for (int unsigned k = 0; k < 4; k++) begin
      symb_w[k] = mapped[k] + phi_cur;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)       phi_q <= '0;
    else if (iclkena) phi_q <= phi_d;
  end
`else
  assign symb_w = mapped;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    oval_d  = oval_q;
    osop_d  = osop_q;
    oeop_d  = oeop_q;
    oerr_d  = 1'b0;
    osymb_d = osymb_q;
    if (accept) begin
      oval_d  = 1'b1;
      osymb_d = symb_w;
      if (isop) begin
        // A sop in RUN is flagged but otherwise restarts the frame like in IDLE.
        len_d   = len_eff;
        cnt_d   = pLEN_W'(1);
        osop_d  = 1'b1;
        oerr_d  = (state_q == ST_RUN);
        oeop_d  = (len_eff == pLEN_W'(1));
        state_d = oeop_d ? ST_IDLE : ST_RUN;
      end else if (state_q == ST_IDLE) begin
        osop_d  = 1'b0;
        oeop_d  = 1'b0;
        oerr_d  = 1'b1;
      end else begin
        cnt_d   = cnt_inc;
        osop_d  = 1'b0;
        oeop_d  = (cnt_inc == len_q);
        state_d = oeop_d ? ST_IDLE : ST_RUN;
      end
    end else if (iordy) begin
      oval_d = 1'b0;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      oval_q  <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      oerr_q  <= 1'b0;
      osymb_q <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      oval_q  <= oval_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      oerr_q  <= oerr_d;
      osymb_q <= osymb_d;
    end
  end

  assign oval  = oval_q;
  assign osop  = osop_q;
  assign oeop  = oeop_q;
  assign oerr  = oerr_q;
  assign osymb = osymb_q;

endmodule

// File: tb/tb_tcm_enc_4d_8psk.sv
// Scoreboard bench for tcm_enc_4d_8psk: directed words, expected records queued at accept, checked at output.
module tb_tcm_enc_4d_8psk;

  logic             iclk = 1'b0;
  logic             ireset;
  logic             iclkena;
  logic [1:0]       icode;
  logic [15:0]      ilen;
  logic             ival;
  logic             isop;
  logic [10:0]      idat;
  logic             ordy;
  logic             iordy;
  logic             oval;
  logic             osop;
  logic             oeop;
  logic [3:0][2:0]  osymb;
  logic             oerr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        err;
    logic [11:0] symb;
  } rec_t;

  rec_t q[$];

  tcm_enc_4d_8psk #(
    .pLEN_W (16)
  ) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .icode   (icode),
    .ilen    (ilen),
    .ival    (ival),
    .isop    (isop),
    .idat    (idat),
    .ordy    (ordy),
    .iordy   (iordy),
    .oval    (oval),
    .osop    (osop),
    .oeop    (oeop),
    .osymb   (osymb),
    .oerr    (oerr)
  );

  always #5 iclk = ~iclk;

  function automatic logic [11:0] s4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic sop, input logic [15:0] len, input logic [1:0] code,
                      input logic [10:0] dat, input logic esop, input logic eeop,
                      input logic eerr, input logic [11:0] esymb);
    int n;
    ival  = 1'b1;
    isop  = sop;
    ilen  = len;
    icode = code;
    idat  = dat;
    n = 0;
    @(negedge iclk);
    while (!ordy && n < 200) begin
      @(negedge iclk);
      n++;
    end
    if (!ordy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ordy=0 expected ordy=1 within 200 cycles");
    end else begin
      q.push_back('{sop: esop, eop: eeop, err: eerr, symb: esymb});
    end
    @(posedge iclk);
    #1;
    ival = 1'b0;
    isop = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  // Monitor: one record per consumed output word.
  initial begin
    rec_t e;
    forever begin
      @(negedge iclk);
      if (!ireset && oval && iordy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got sop=%0b eop=%0b err=%0b symb=%0h expected none",
                   osop, oeop, oerr, osymb);
        end else begin
          e = q.pop_front();
          chk("word{sop,eop,err,symb}", 32'({osop, oeop, oerr, osymb}), 32'(e));
        end
      end
    end
  end

  initial begin
    int n;
    ireset  = 1'b1;
    iclkena = 1'b1;
    icode   = 2'd0;
    ilen    = 16'd0;
    ival    = 1'b0;
    isop    = 1'b0;
    idat    = '0;
    iordy   = 1'b1;

    repeat (3) @(negedge iclk);
    chk("reset_oval",  32'(oval),  32'd0);
    chk("reset_osop",  32'(osop),  32'd0);
    chk("reset_oeop",  32'(oeop),  32'd0);
    chk("reset_oerr",  32'(oerr),  32'd0);
    chk("reset_osymb", 32'(osymb), 32'd0);
    chk("reset_ordy",  32'(ordy),  32'd1);
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    gap(2);

    // All-zero frame of four words.
    send(1, 16'd4, 2'd0, 11'h000, 1, 0, 0, s4(0,0,0,0));
    send(0, 16'd4, 2'd0, 11'h000, 0, 0, 0, s4(0,0,0,0));
    send(0, 16'd4, 2'd0, 11'h000, 0, 0, 0, s4(0,0,0,0));
    send(0, 16'd4, 2'd0, 11'h000, 0, 1, 0, s4(0,0,0,0));

    // Parity bit appears two words after x1=1 from zero state.
    send(1, 16'd3, 2'd0, 11'h001, 1, 0, 0, s4(0,2,0,2));
    send(0, 16'd3, 2'd0, 11'h000, 0, 0, 0, s4(0,0,0,0));
    send(0, 16'd3, 2'd0, 11'h000, 0, 1, 0, s4(1,1,1,1));

    // Code-width masking, then the widest code.
    send(1, 16'd2, 2'd0, 11'h700, 1, 0, 0, s4(0,0,0,0));
    send(0, 16'd2, 2'd3, 11'h700, 0, 1, 0, s4(0,1,1,3));

    // ilen = 0 acts as 1; a following word without sop is a framing error.
    send(1, 16'd0, 2'd0, 11'h000, 1, 1, 0, s4(0,0,0,0));
    send(0, 16'd0, 2'd0, 11'h002, 0, 0, 1, s4(0,0,2,2));

    // icode = 1 keeps w8, drops w9.
    send(1, 16'd1, 2'd1, 11'h300, 1, 1, 0, s4(0,1,0,1));

    // Backpressure: five stalled cycles with a pending word.
    gap(3);
    iordy = 1'b0;
    send(1, 16'd3, 2'd0, 11'h008, 1, 0, 0, s4(2,2,2,2));
    ival  = 1'b1;
    isop  = 1'b0;
    idat  = 11'h010;
    for (int i = 0; i < 5; i++) begin
      @(negedge iclk);
      chk("stall_ordy",  32'(ordy),  32'd0);
      chk("stall_osymb", 32'(osymb), 32'(s4(2,2,2,2)));
    end
    @(posedge iclk);
    #1;
    iordy = 1'b1;
    send(0, 16'd3, 2'd0, 11'h010, 0, 0, 0, s4(0,0,0,4));
    send(0, 16'd3, 2'd0, 11'h020, 0, 1, 0, s4(0,0,4,0));

    // sop at cnt = 2 inside a five-word frame restarts with a cleared state.
    send(1, 16'd5, 2'd0, 11'h001, 1, 0, 0, s4(0,2,0,2));
    send(0, 16'd5, 2'd0, 11'h000, 0, 0, 0, s4(0,0,0,0));
    send(1, 16'd2, 2'd0, 11'h000, 1, 0, 1, s4(0,0,0,0));
    send(0, 16'd2, 2'd0, 11'h004, 0, 1, 0, s4(0,0,0,2));

    // Top uncoded bit: rotated by 180 degrees on the next word only with the diff option.
    send(1, 16'd2, 2'd0, 11'h080, 1, 0, 0, s4(4,0,0,0));
`ifdef TCM_ENC_DIFF_EN
    send(0, 16'd2, 2'd0, 11'h000, 0, 1, 0, s4(4,4,4,4));
`else
    send(0, 16'd2, 2'd0, 11'h000, 0, 1, 0, s4(0,0,0,0));
`endif

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge iclk);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
    gap(2);
    chk("idle_oval", 32'(oval), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
